pcie_perst_seq: RTL and testbench

PCIe fundamental-reset (PERST#) sequencer for the simulation board and bring-up designs. It sits directly upstream of the root-port model's `sys_rst_n` and the endpoint's PERST input:
- holds PERST# low for a fixed number of reference-clock cycles after board reset;
- releases it and supervises link training with a timeout and bounded retries;
- counts link drops and re-enters training on each drop.

---
 rtl/pcie_perst_seq_pkg.sv | 19 +
 rtl/pcie_perst_seq_sync_2ff.sv | 31 +++
 rtl/pcie_perst_seq.sv | 116 +++++++++++
 tb/tb_pcie_perst_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_perst_seq_pkg.sv
// Shared types and constants for the PCIe PERST# sequencer.
package pcie_perst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_UP     = 2'd2,
        ST_FAIL   = 2'd3
    } perst_state_e;

    localparam int DROP_W  = 8;
    localparam int RETRY_W = 2;

    // Drop counter sticks at all-ones rather than wrapping.
    function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/pcie_perst_seq_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pcie_perst_seq.sv
// PERST# sequencer: holds PERST# low after reset, then supervises link
// training with a timeout and bounded retries, and counts link drops.
module pcie_perst_seq
    import pcie_perst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES    = 500,
    parameter int LINKUP_TIMEOUT = 1000000,
    parameter int CNT_W          = 20,
    parameter int RETRY_MAX      = 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               reset_req,
    input  logic               user_lnk_up,
    output logic               perst_n,
    output logic               busy,
    output logic               link_ok,
    output logic               timeout,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [DROP_W-1:0]  drop_cnt
);

    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TRAIN_LAST  = CNT_W'(LINKUP_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(RETRY_MAX);

    perst_state_e       state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [RETRY_W-1:0] retry_d, retry_q;
    logic [DROP_W-1:0]  drop_d, drop_q;
    logic               lnk_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lnk_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (user_lnk_up),
        .q     (lnk_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        retry_d = retry_q;
        drop_d  = drop_q;

        // A restart request overrides everything, including a same-cycle drop.
        if (reset_req) begin
            state_d = ST_ASSERT;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_TRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_TRAIN: begin
                    if (lnk_s) begin
                        state_d = ST_UP;
                    end else if (cnt_q == TRAIN_LAST) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = ST_FAIL;
                        end else begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = ST_ASSERT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_UP: begin
                    if (!lnk_s) begin
                        drop_d  = drop_sat_inc(drop_q);
                        state_d = ST_TRAIN;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            retry_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs come purely from registered state so no input reaches a pin combinationally.
    always_comb begin
        perst_n = (state_q == ST_TRAIN) || (state_q == ST_UP);
        busy    = (state_q == ST_ASSERT) || (state_q == ST_TRAIN);
        link_ok = (state_q == ST_UP);
        timeout = (state_q == ST_FAIL);
    end

    assign retry_cnt = retry_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pcie_perst_seq.sv
// Self-checking bench for pcie_perst_seq against a phase/timer reference model.
module tb_pcie_perst_seq;

    localparam int HOLD    = 4;
    localparam int TMO     = 10;
    localparam int RMAX    = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       reset_req;
    logic       user_lnk_up;
    logic       perst_n, busy, link_ok, timeout;
    logic [1:0] retry_cnt;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: time left in the hold phase, time spent training,
    // linked / failed flags, counters, and a 2-sample delay line for the link.
    int m_hold_left;
    int m_train_age;
    bit m_linked;
    bit m_failed;
    int m_retries;
    int m_drops;
    bit m_hist[$];

    pcie_perst_seq #(
        .HOLD_CYCLES    (HOLD),
        .LINKUP_TIMEOUT (TMO),
        .CNT_W          (8),
        .RETRY_MAX      (RMAX)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .reset_req   (reset_req),
        .user_lnk_up (user_lnk_up),
        .perst_n     (perst_n),
        .busy        (busy),
        .link_ok     (link_ok),
        .timeout     (timeout),
        .retry_cnt   (retry_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hold_left = HOLD;
        m_train_age = 0;
        m_linked    = 1'b0;
        m_failed    = 1'b0;
        m_retries   = 0;
        m_drops     = 0;
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
    endtask

    task automatic model_edge(input bit req, input bit lnk);
        bit ls;
        ls = m_hist.pop_front();
        m_hist.push_back(lnk);
        if (req) begin
            m_hold_left = HOLD;
            m_train_age = 0;
            m_linked    = 1'b0;
            m_failed    = 1'b0;
            m_retries   = 0;
        end else if (m_failed) begin
            m_failed = 1'b1;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            m_train_age = 0;
        end else if (m_linked) begin
            if (!ls) begin
                m_drops     = (m_drops < 255) ? m_drops + 1 : 255;
                m_linked    = 1'b0;
                m_train_age = 0;
            end
        end else if (ls) begin
            m_linked = 1'b1;
        end else begin
            m_train_age++;
            if (m_train_age == TMO) begin
                if (m_retries == RMAX) m_failed = 1'b1;
                else begin
                    m_retries++;
                    m_hold_left = HOLD;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("perst_n",   perst_n,   32'(!m_failed && m_hold_left == 0));
        check("busy",      busy,      32'(!m_failed && !m_linked));
        check("link_ok",   link_ok,   32'(m_linked));
        check("timeout",   timeout,   32'(m_failed));
        check("retry_cnt", retry_cnt, 32'(m_retries));
        check("drop_cnt",  drop_cnt,  32'(m_drops));
    endtask

    task automatic step(input bit req, input bit lnk);
        @(negedge sys_clk);
        reset_req   = req;
        user_lnk_up = lnk;
        @(posedge sys_clk);
        model_edge(req, lnk);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_perst_n"}, perst_n,   32'd0);
        check({tag, "_busy"},    busy,      32'd1);
        check({tag, "_link_ok"}, link_ok,   32'd0);
        check({tag, "_timeout"}, timeout,   32'd0);
        check({tag, "_retry"},   retry_cnt, 32'd0);
        check({tag, "_drop"},    drop_cnt,  32'd0);
    endtask

    initial begin
        int saved_drops;
        sys_rst_n   = 1'b0;
        reset_req   = 1'b0;
        user_lnk_up = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_values("por");
        sys_rst_n = 1'b1;
        model_reset();

        // Power-on release, link comes up at cycle 6.
        for (int c = 1; c <= 12; c++) begin
            step(1'b0, c >= 6);
            if (c == 3) check("perst_low_edge3", perst_n, 32'd0);
            if (c == 4) check("perst_high_edge4", perst_n, 32'd1);
            if (c == 7) check("linkok_pre", link_ok, 32'd0);
            if (c == 8) check("linkok_edge8", link_ok, 32'd1);
        end
        check("s1_busy", busy, 32'd0);
        check("s1_retry", retry_cnt, 32'd0);

        // Link falls on the same edge reset_req is sampled: no drop counted.
        saved_drops = int'(drop_cnt);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("pre_same_linkok", link_ok, 32'd1);
        step(1'b1, 1'b0);
        check("same_perst", perst_n, 32'd0);
        check("same_drop", drop_cnt, 32'(saved_drops));

        // Link held low: three rounds, then FAIL.
        for (int c = 0; c < 50; c++) begin
            step(1'b0, 1'b0);
            if (c == HOLD + TMO - 1) check("retry_step1", retry_cnt, 32'd1);
            if (c == 2 * (HOLD + TMO) - 1) check("retry_step2", retry_cnt, 32'd2);
        end
        check("fail_timeout", timeout, 32'd1);
        check("fail_perst", perst_n, 32'd0);
        check("fail_busy", busy, 32'd0);

        // Restart out of FAIL.
        step(1'b1, 1'b0);
        check("rst_timeout", timeout, 32'd0);
        check("rst_retry", retry_cnt, 32'd0);
        for (int c = 1; c <= HOLD; c++) begin
            step(1'b0, 1'b0);
            check("rst_perst", perst_n, 32'(c == HOLD));
        end
        step(1'b0, 1'b0);

        // Asynchronous reset while training, away from any clock edge.
        #3;
        sys_rst_n = 1'b0;
        #1;
        check_reset_values("async");
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        model_reset();

        // Bring link up, then 300 drops with random low/high run lengths.
        for (int c = 0; c < 10; c++) step(1'b0, 1'b1);
        check("pre_drop_up", link_ok, 32'd1);
        for (int d = 0; d < 300; d++) begin
            int lo, hi;
            lo = int'($urandom_range(1, 3));
            hi = int'($urandom_range(3, 6));
            for (int c = 0; c < lo; c++) step(1'b0, 1'b0);
            for (int c = 0; c < hi; c++) step(1'b0, 1'b1);
        end
        check("drop_sat", drop_cnt, 32'd255);
        check("drop_relink", link_ok, 32'd1);

        // Random traffic: link runs of random length, occasional restarts.
        begin
            bit lnk;
            int run;
            lnk = 1'b0;
            run = 0;
            for (int c = 0; c < 1500; c++) begin
                if (run == 0) begin
                    lnk = ~lnk;
                    run = int'($urandom_range(1, 30));
                end
                run--;
                step(($urandom_range(0, 59) == 0), lnk);
            end
        end
        reset_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
